// File: rtl/pmod_gpio_pkg.sv
// Shared constants and helpers for the PMOD GPIO controller:
// register map, ID magic and compile-time width helpers.
package pmod_gpio_pkg;

  localparam logic [2:0]  ADDR_DIR  = 3'd0;
  localparam logic [2:0]  ADDR_OUT  = 3'd1;
  localparam logic [2:0]  ADDR_IN   = 3'd2;
  localparam logic [2:0]  ADDR_EVT  = 3'd3;
  localparam logic [2:0]  ADDR_IEN  = 3'd4;
  localparam logic [2:0]  ADDR_ESEL = 3'd5;
  localparam logic [2:0]  ADDR_ID   = 3'd6;

  localparam logic [15:0] ID_MAGIC  = 16'h9A10;

  // Debounce counter width; never narrower than one bit.
  function automatic int cnt_width(input int deb);
    return (deb > 2) ? $clog2(deb) : 1;
  endfunction

  // ID word: magic, debounce depth clipped to a byte, pin count.
  function automatic logic [31:0] id_word(input int npin, input int deb);
    logic [7:0] deb_b;
    deb_b = (deb > 255) ? 8'd255 : 8'(deb);
    return {ID_MAGIC, deb_b, 8'(npin)};
  endfunction

endpackage

// File: rtl/pmod_debounce.sv
// One-bit input path: two-flop synchroniser followed by a counting debouncer
// that accepts a new level only after DEBOUNCE consecutive mismatching cycles.
module pmod_debounce
  import pmod_gpio_pkg::*;
#(
  parameter int DEBOUNCE = 16
) (
  input  logic clk,
  input  logic resn,
  input  logic pin_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int              CW   = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0]   CMAX = CW'(DEBOUNCE - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchroniser shift and debounce counter next state.
  always_comb begin
    sync1_d = pin_i;
    sync2_d = sync1_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    if (sync2_q == s_q) begin
      cnt_d = '0;
    end else if (cnt_q == CMAX) begin
      s_d   = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      s_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pulses mark the edge at which the stable level flips.
  assign s_o    = s_q;
  assign rise_o = ~s_q & s_d;
  assign fall_o = s_q & ~s_d;

endmodule

// File: rtl/pmod_gpio.sv
// Register-mapped PMOD GPIO: direction/output registers, debounced inputs,
// edge-selectable sticky event flags with W1C clear, and a level interrupt.
module pmod_gpio
  import pmod_gpio_pkg::*;
#(
  parameter int NPIN     = 8,
  parameter int DEBOUNCE = 16
) (
  input  logic            CLK,
  input  logic            RESN,
  input  logic [2:0]      ADDR,
  input  logic            WR,
  input  logic            RD,
  input  logic [31:0]     WDATA,
  output logic [31:0]     RDATA,
  output logic            IRQ,
  input  logic [NPIN-1:0] PIO_I,
  output logic [NPIN-1:0] PIO_O,
  output logic [NPIN-1:0] PIO_OE
);

  localparam logic [31:0] ID_WORD = id_word(NPIN, DEBOUNCE);

  logic [NPIN-1:0] dir_q, dir_d;
  logic [NPIN-1:0] out_q, out_d;
  logic [NPIN-1:0] evt_q, evt_d;
  logic [NPIN-1:0] ien_q, ien_d;
  logic [NPIN-1:0] esel_q, esel_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            irq_q, irq_d;

  logic [NPIN-1:0] in_s, rise_s, fall_s;
  logic [NPIN-1:0] wdata_s, evt_clr_s, evt_set_s;
  logic [31:0]     rd_word_s;
  logic            unused_wdata_s;

  assign wdata_s        = WDATA[NPIN-1:0];
  assign unused_wdata_s = ^WDATA;

  for (genvar g = 0; g < NPIN; g++) begin : g_pin
    pmod_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clk    (CLK),
      .resn   (RESN),
      .pin_i  (PIO_I[g]),
      .s_o    (in_s[g]),
      .rise_o (rise_s[g]),
      .fall_o (fall_s[g])
    );
  end

  // Read mux over pre-write register values.
  always_comb begin
    rd_word_s = '0;
    case (ADDR)
      ADDR_DIR:  rd_word_s = 32'(dir_q);
      ADDR_OUT:  rd_word_s = 32'(out_q);
      ADDR_IN:   rd_word_s = 32'(in_s);
      ADDR_EVT:  rd_word_s = 32'(evt_q);
      ADDR_IEN:  rd_word_s = 32'(ien_q);
      ADDR_ESEL: rd_word_s = 32'(esel_q);
      ADDR_ID:   rd_word_s = ID_WORD;
      default:   rd_word_s = '0;
    endcase
  end

  // Register writes, event set/clear (set wins), IRQ from next-state flags.
  always_comb begin
    dir_d     = dir_q;
    out_d     = out_q;
    ien_d     = ien_q;
    esel_d    = esel_q;
    evt_clr_s = '0;
    if (WR) begin
      case (ADDR)
        ADDR_DIR:  dir_d     = wdata_s;
        ADDR_OUT:  out_d     = wdata_s;
        ADDR_EVT:  evt_clr_s = wdata_s;
        ADDR_IEN:  ien_d     = wdata_s;
        ADDR_ESEL: esel_d    = wdata_s;
        default:   evt_clr_s = '0;
      endcase
    end else begin
      evt_clr_s = '0;
    end
    evt_set_s = (rise_s & ~esel_q) | (fall_s & esel_q);
    evt_d     = (evt_q & ~evt_clr_s) | evt_set_s;
    irq_d     = |(evt_d & ien_d);
    rdata_d   = RD ? rd_word_s : rdata_q;
  end

  // Register file and bus outputs, synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESN) begin
      dir_q   <= '0;
      out_q   <= '0;
      evt_q   <= '0;
      ien_q   <= '0;
      esel_q  <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      dir_q   <= dir_d;
      out_q   <= out_d;
      evt_q   <= evt_d;
      ien_q   <= ien_d;
      esel_q  <= esel_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign PIO_OE = dir_q;
  assign PIO_O  = out_q;
  assign RDATA  = rdata_q;
  assign IRQ    = irq_q;

endmodule

// File: tb/tb_pmod_gpio.sv
// Bench for pmod_gpio: a window-based input model plus register model checked
// every cycle, and directed sequences with literal expectations.
module tb_pmod_gpio;

  localparam int NPIN = 8;
  localparam int DEB  = 16;

  logic            CLK = 1'b0;
  logic            RESN = 1'b0;
  logic [2:0]      ADDR = 3'd0;
  logic            WR = 1'b0;
  logic            RD = 1'b0;
  logic [31:0]     WDATA = 32'd0;
  logic [31:0]     RDATA;
  logic            IRQ;
  logic [NPIN-1:0] PIO_I = '0;
  logic [NPIN-1:0] PIO_O;
  logic [NPIN-1:0] PIO_OE;

  int n_tests = 0;
  int n_fail  = 0;

  pmod_gpio #(.NPIN(NPIN), .DEBOUNCE(DEB)) dut (
    .CLK(CLK), .RESN(RESN), .ADDR(ADDR), .WR(WR), .RD(RD), .WDATA(WDATA),
    .RDATA(RDATA), .IRQ(IRQ), .PIO_I(PIO_I), .PIO_O(PIO_O), .PIO_OE(PIO_OE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- model: a level is accepted when the last DEB synchronised samples all differ
  logic [NPIN-1:0] m_hist [0:DEB];
  int              m_nvalid = 0;
  logic [NPIN-1:0] m_s = '0, m_dir = '0, m_out = '0, m_evt = '0, m_ien = '0, m_esel = '0;
  logic [31:0]     m_rdata = '0;
  logic            m_irq = 1'b0;
  logic            m_valid = 1'b0;

  logic [NPIN-1:0] m_flip, m_set, m_clr, m_evt_n, m_ien_n;
  logic [31:0]     m_rd;

  always_comb begin
    m_flip = '0;
    if (m_nvalid > DEB) begin
      for (int i = 0; i < NPIN; i++) begin
        m_flip[i] = 1'b1;
        for (int j = 1; j <= DEB; j++) begin
          if (m_hist[j][i] == m_s[i]) m_flip[i] = 1'b0;
        end
      end
    end
    m_set   = (m_flip & ~m_s & ~m_esel) | (m_flip & m_s & m_esel);
    m_clr   = (WR && ADDR == 3'd3) ? WDATA[NPIN-1:0] : '0;
    m_evt_n = (m_evt & ~m_clr) | m_set;
    m_ien_n = (WR && ADDR == 3'd4) ? WDATA[NPIN-1:0] : m_ien;
    case (ADDR)
      3'd0:    m_rd = {24'd0, m_dir};
      3'd1:    m_rd = {24'd0, m_out};
      3'd2:    m_rd = {24'd0, m_s};
      3'd3:    m_rd = {24'd0, m_evt};
      3'd4:    m_rd = {24'd0, m_ien};
      3'd5:    m_rd = {24'd0, m_esel};
      3'd6:    m_rd = 32'h9A10_1008;
      default: m_rd = 32'd0;
    endcase
  end

  always @(posedge CLK) begin
    m_valid <= 1'b1;
    if (!RESN) begin
      m_nvalid <= 0;
      m_s <= '0; m_dir <= '0; m_out <= '0; m_evt <= '0; m_ien <= '0; m_esel <= '0;
      m_rdata <= '0; m_irq <= 1'b0;
    end else begin
      m_nvalid <= (m_nvalid > DEB) ? m_nvalid : m_nvalid + 1;
      m_hist[0] <= PIO_I;
      for (int j = 1; j <= DEB; j++) m_hist[j] <= m_hist[j-1];
      m_s   <= m_s ^ m_flip;
      m_evt <= m_evt_n;
      m_ien <= m_ien_n;
      m_irq <= |(m_evt_n & m_ien_n);
      if (RD) m_rdata <= m_rd;
      if (WR && ADDR == 3'd0) m_dir  <= WDATA[NPIN-1:0];
      if (WR && ADDR == 3'd1) m_out  <= WDATA[NPIN-1:0];
      if (WR && ADDR == 3'd5) m_esel <= WDATA[NPIN-1:0];
    end
  end

  // Continuous compare against the model, away from the active edge.
  always @(negedge CLK) begin
    if (m_valid) begin
      chk("m_pio_oe", {24'd0, PIO_OE}, {24'd0, m_dir});
      chk("m_pio_o",  {24'd0, PIO_O},  {24'd0, m_out});
      chk("m_rdata",  RDATA,           m_rdata);
      chk("m_irq",    {31'd0, IRQ},    {31'd0, m_irq});
    end
  end

  // ---- bus tasks: called right after a negedge, return right after the next one
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    ADDR = a; WDATA = d; WR = 1'b1;
    @(negedge CLK);
    WR = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    ADDR = a; RD = 1'b1;
    @(negedge CLK);
    RD = 1'b0;
    d = RDATA;
  endtask

  task automatic rdwr(input logic [2:0] a, input logic [31:0] wd, output logic [31:0] d);
    ADDR = a; WDATA = wd; RD = 1'b1; WR = 1'b1;
    @(negedge CLK);
    RD = 1'b0; WR = 1'b0;
    d = RDATA;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  logic [31:0] r;

  initial begin
    idle(2);
    chk("rst_oe",    {24'd0, PIO_OE}, 32'd0);
    chk("rst_o",     {24'd0, PIO_O},  32'd0);
    chk("rst_rdata", RDATA,           32'd0);
    chk("rst_irq",   {31'd0, IRQ},    32'd0);
    RESN = 1'b1;
    idle(1);

    rd(3'd6, r);  chk("id", r, 32'h9A10_1008);
    wr(3'd0, 32'h0000_000F);
    wr(3'd1, 32'h0000_00A5);
    chk("pio_oe", {24'd0, PIO_OE}, 32'h0000_000F);
    chk("pio_o",  {24'd0, PIO_O},  32'h0000_00A5);
    rd(3'd1, r);  chk("rd_out", r, 32'h0000_00A5);
    wr(3'd0, 32'hFFFF_FF0F);
    rd(3'd0, r);  chk("dir_upper", r, 32'h0000_000F);
    rd(3'd7, r);  chk("addr7", r, 32'd0);

    // Debounce latency on pin 0 observed through IRQ.
    wr(3'd4, 32'h0000_0001);
    PIO_I[0] = 1'b1;
    idle(17);     chk("deb_early", {31'd0, IRQ}, 32'd0);
    idle(1);      chk("deb_irq",   {31'd0, IRQ}, 32'd1);
    rd(3'd2, r);  chk("deb_in",  r, 32'h0000_0001);
    rd(3'd3, r);  chk("deb_evt", r, 32'h0000_0001);
    wr(3'd3, 32'h0000_0001);
    chk("w1c_irq", {31'd0, IRQ}, 32'd0);

    // Glitch of DEB-1 cycles on pin 1 is rejected.
    PIO_I[1] = 1'b1;
    idle(15);
    PIO_I[1] = 1'b0;
    idle(20);
    rd(3'd2, r);  chk("glitch_in",  r, 32'h0000_0001);
    rd(3'd3, r);  chk("glitch_evt", r, 32'd0);

    // Falling-edge select on pin 2.
    wr(3'd5, 32'h0000_0004);
    wr(3'd4, 32'h0000_0004);
    PIO_I[2] = 1'b1;
    idle(20);
    chk("esel_rise_irq", {31'd0, IRQ}, 32'd0);
    rd(3'd3, r);  chk("esel_rise_evt", r, 32'd0);
    rd(3'd2, r);  chk("esel_in", r, 32'h0000_0005);
    PIO_I[2] = 1'b0;
    idle(18);
    chk("esel_fall_irq", {31'd0, IRQ}, 32'd1);
    rd(3'd3, r);  chk("esel_fall_evt", r, 32'h0000_0004);
    wr(3'd3, 32'h0000_0004);
    chk("esel_clr_irq", {31'd0, IRQ}, 32'd0);
    rd(3'd3, r);  chk("esel_clr_evt", r, 32'd0);

    // W1C landing on the same edge that sets EVT[3]: set wins.
    wr(3'd5, 32'h0000_0000);
    wr(3'd4, 32'h0000_0008);
    PIO_I[3] = 1'b1;
    idle(17);
    chk("race_pre_irq", {31'd0, IRQ}, 32'd0);
    wr(3'd3, 32'h0000_0008);
    chk("race_irq", {31'd0, IRQ}, 32'd1);
    rd(3'd3, r);  chk("race_evt", r, 32'h0000_0008);
    wr(3'd3, 32'h0000_0008);
    chk("race_clr_irq", {31'd0, IRQ}, 32'd0);

    // Read and write to the same address in one cycle returns the old value.
    wr(3'd4, 32'h0000_0055);
    rdwr(3'd4, 32'h0000_00AA, r);  chk("rdwr_old", r, 32'h0000_0055);
    rd(3'd4, r);                   chk("rdwr_new", r, 32'h0000_00AA);

    // Reset in the middle of a debounce count on pin 4.
    PIO_I[4] = 1'b1;
    idle(12);
    RESN = 1'b0;
    idle(2);
    chk("mid_rst_oe",    {24'd0, PIO_OE}, 32'd0);
    chk("mid_rst_rdata", RDATA,           32'd0);
    chk("mid_rst_irq",   {31'd0, IRQ},    32'd0);
    RESN = 1'b1;
    idle(10);
    rd(3'd2, r);  chk("post_rst_in_early", r, 32'd0);
    idle(10);
    rd(3'd2, r);  chk("post_rst_in", r, 32'h0000_0019);
    rd(3'd3, r);  chk("post_rst_evt", r, 32'h0000_0019);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
